// File: rtl/lcb_rx_pkg.sv
// Shared types and constants for the LCB receive framer.
package lcb_rx_pkg;

    // Framer FSM states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_FIRST,
        ST_RECV,
        ST_CHECK,
        ST_REPLAY,
        ST_FINISH
    } lcb_rx_state_t;

    // Window result codes reported on oErrCode
    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_TMO  = 2'd1;
    localparam logic [1:0] ERR_CSUM = 2'd2;
    localparam logic [1:0] ERR_SYNC = 2'd3;

    // Default value expected in byte 0 of every reply
    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    // Width of byte counters / buffer addresses (64-entry buffer)
    localparam int IDX_W = 6;

endpackage

// File: rtl/lcb_rx_buf.sv
// 64x8 simple dual-port reply buffer: one write port fed while receiving,
// one read port with a registered output used while replaying.
module lcb_rx_buf
    import lcb_rx_pkg::*;
(
    input  logic             clk,
    input  logic             we_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  logic [7:0]       wdata_i,
    input  logic [IDX_W-1:0] raddr_i,
    output logic [7:0]       rdata_o
);

    logic [7:0] mem_q [0:(2**IDX_W)-1];
    logic [7:0] rdata_q;

    // Storage write and registered read; contents need no reset
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/lcb_rx_framer.sv
// LCB reply receive framer: opens a window on iStart, collects EXP_BYTES
// bytes from the UART receiver, verifies sync byte, inter-byte timing and
// the 8-bit additive checksum, then replays the verified payload with an
// index. Every window ends with exactly one oDone pulse (unless reset).
// Optional frame statistics are enabled with macro LCB_RX_STATS_EN.
module lcb_rx_framer
    import lcb_rx_pkg::*;
#(
    parameter int         EXP_BYTES = 24,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
    parameter int         FIRST_TO  = 16000,
    parameter int         GAP_TO    = 400
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iStart,
    input  logic [7:0]  iData,
    input  logic        iValid,
    output logic [7:0]  oData,
    output logic [5:0]  oIdx,
    output logic        oValid,
    output logic        oDone,
    output logic        oErr,
    output logic [1:0]  oErrCode,
    output logic        oBusy,
    output logic [15:0] oCntOk,
    output logic [15:0] oCntErr
);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(EXP_BYTES - 1);
    localparam logic [IDX_W-1:0] LAST_PAY  = IDX_W'(EXP_BYTES - 2);
    localparam logic [15:0]      TMO_FIRST = 16'(FIRST_TO);
    localparam logic [15:0]      TMO_GAP   = 16'(GAP_TO);

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    lcb_rx_state_t    state_q, state_d;
    logic [15:0]      timer_q, timer_d;
    logic [IDX_W-1:0] cnt_q,   cnt_d;
    logic [7:0]       sum_q,   sum_d;
    logic [7:0]       csum_q,  csum_d;
    logic             done_q,  done_d;
    logic             err_q,   err_d;
    logic [1:0]       ecode_q, ecode_d;

    logic             buf_we;
    logic [IDX_W-1:0] buf_waddr;
    logic [7:0]       buf_wdata;
    logic [IDX_W-1:0] buf_raddr;
    logic [7:0]       buf_rdata;

    lcb_rx_buf u_buf (
        .clk     (clk),
        .we_i    (buf_we),
        .waddr_i (buf_waddr),
        .wdata_i (buf_wdata),
        .raddr_i (buf_raddr),
        .rdata_o (buf_rdata)
    );

    // Next-state, timer, checksum and buffer-port control
    always_comb begin
        state_d   = state_q;
        timer_d   = sat_inc16(timer_q);
        cnt_d     = cnt_q;
        sum_d     = sum_q;
        csum_d    = csum_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        ecode_d   = ecode_q;
        buf_we    = 1'b0;
        buf_waddr = cnt_q;
        buf_wdata = iData;
        buf_raddr = '0;

        // The timer holds cycles elapsed since the last restart event; the
        // event cycle itself counts as 0, so the following cycle reads 1.
        unique case (state_q)
            ST_IDLE: begin
                timer_d = '0;
                if (iStart) begin
                    state_d = ST_WAIT_FIRST;
                    timer_d = 16'd1;
                    cnt_d   = '0;
                    sum_d   = '0;
                end
            end
            ST_WAIT_FIRST: begin
                if (timer_q >= TMO_FIRST) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    ecode_d = ERR_TMO;
                end else if (iValid) begin
                    if (iData != SYNC_BYTE) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        ecode_d = ERR_SYNC;
                    end else begin
                        buf_we  = 1'b1;
                        sum_d   = iData;
                        cnt_d   = IDX_W'(1);
                        timer_d = 16'd1;
                        state_d = ST_RECV;
                    end
                end
            end
            ST_RECV: begin
                if (timer_q >= TMO_GAP) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    ecode_d = ERR_TMO;
                end else if (iValid) begin
                    buf_we  = 1'b1;
                    timer_d = 16'd1;
                    if (cnt_q == LAST_IDX) begin
                        csum_d  = iData;
                        state_d = ST_CHECK;
                    end else begin
                        sum_d = sum_q + iData;
                        cnt_d = cnt_q + IDX_W'(1);
                    end
                end
            end
            ST_CHECK: begin
                // Address 0 is presented here so it is ready in the first replay cycle
                buf_raddr = '0;
                cnt_d     = '0;
                if (sum_q == csum_q) begin
                    state_d = ST_REPLAY;
                end else begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    ecode_d = ERR_CSUM;
                end
            end
            ST_REPLAY: begin
                // Read one entry ahead of the byte currently on oData
                buf_raddr = cnt_q + IDX_W'(1);
                if (cnt_q == LAST_PAY) begin
                    state_d = ST_FINISH;
                    done_d  = 1'b1;
                    err_d   = 1'b0;
                    ecode_d = ERR_NONE;
                end else begin
                    cnt_d = cnt_q + IDX_W'(1);
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A new request while a window is open aborts it and restarts cleanly
        if (iStart && (state_q != ST_IDLE)) begin
            state_d = ST_WAIT_FIRST;
            timer_d = 16'd1;
            cnt_d   = '0;
            sum_d   = '0;
            buf_we  = 1'b0;
            done_d  = 1'b1;
            err_d   = 1'b1;
            ecode_d = ERR_SYNC;
        end
    end

    // State and result registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            csum_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ecode_q <= ERR_NONE;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            csum_q  <= csum_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ecode_q <= ecode_d;
        end
    end

    // Replay data comes straight from the registered buffer read
    assign oValid   = (state_q == ST_REPLAY);
    assign oData    = oValid ? buf_rdata : 8'h00;
    assign oIdx     = oValid ? cnt_q : '0;
    assign oDone    = done_q;
    assign oErr     = err_q;
    assign oErrCode = ecode_q;
    assign oBusy    = (state_q != ST_IDLE);

`ifdef LCB_RX_STATS_EN
    logic [15:0] cnt_ok_q;
    logic [15:0] cnt_err_q;

    // Saturating good/bad frame counters, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_ok_q  <= '0;
            cnt_err_q <= '0;
        end else if (done_d) begin
            if (err_d) begin
                cnt_err_q <= sat_inc16(cnt_err_q);
            end else begin
                cnt_ok_q <= sat_inc16(cnt_ok_q);
            end
        end
    end

    assign oCntOk  = cnt_ok_q;
    assign oCntErr = cnt_err_q;
`else
    assign oCntOk  = 16'h0000;
    assign oCntErr = 16'h0000;
`endif

endmodule

// File: tb/tb_lcb_rx_framer.sv
// Scoreboard bench for lcb_rx_framer (EXP_BYTES=4, GAP_TO=20, FIRST_TO=100).
module tb_lcb_rx_framer;

    logic        clk;
    logic        reset;
    logic        iStart;
    logic [7:0]  iData;
    logic        iValid;
    logic [7:0]  oData;
    logic [5:0]  oIdx;
    logic        oValid;
    logic        oDone;
    logic        oErr;
    logic [1:0]  oErrCode;
    logic        oBusy;
    logic [15:0] oCntOk;
    logic [15:0] oCntErr;

    lcb_rx_framer #(
        .EXP_BYTES (4),
        .SYNC_BYTE (8'hA5),
        .FIRST_TO  (100),
        .GAP_TO    (20)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .iStart   (iStart),
        .iData    (iData),
        .iValid   (iValid),
        .oData    (oData),
        .oIdx     (oIdx),
        .oValid   (oValid),
        .oDone    (oDone),
        .oErr     (oErr),
        .oErrCode (oErrCode),
        .oBusy    (oBusy),
        .oCntOk   (oCntOk),
        .oCntErr  (oCntErr)
    );

    typedef struct {
        logic       is_done;
        int         cyc;
        logic [7:0] data;
        logic [5:0] idx;
        logic       err;
        logic [1:0] code;
    } exp_t;

    exp_t       expq [$];
    exp_t       mon_e;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] frm [0:3];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: compare every presented output against the expectation queue
    always @(negedge clk) begin
        if (oValid) begin
            if (expq.size() == 0) begin
                chk("unexpected oValid", 32'd1, 32'd0);
            end else begin
                mon_e = expq.pop_front();
                chk("valid where done expected", 32'(mon_e.is_done), 32'd0);
                chk("oValid cycle", cyc, mon_e.cyc);
                chk("oData", 32'(oData), 32'(mon_e.data));
                chk("oIdx", 32'(oIdx), 32'(mon_e.idx));
            end
        end
        if (oDone) begin
            if (expq.size() == 0) begin
                chk("unexpected oDone", 32'd1, 32'd0);
            end else begin
                mon_e = expq.pop_front();
                chk("done where valid expected", 32'(mon_e.is_done), 32'd1);
                chk("oDone cycle", cyc, mon_e.cyc);
                chk("oErr", 32'(oErr), 32'(mon_e.err));
                chk("oErrCode", 32'(oErrCode), 32'(mon_e.code));
            end
        end
    end

    task automatic cyc_drive(input logic s, input logic v, input logic [7:0] d, output int p);
        @(negedge clk);
        iStart = s;
        iValid = v;
        iData  = d;
        p      = cyc;
    endtask

    task automatic idle(input int n);
        int p;
        repeat (n) cyc_drive(1'b0, 1'b0, 8'h00, p);
    endtask

    task automatic start(output int p);
        cyc_drive(1'b1, 1'b0, 8'h00, p);
    endtask

    // Sends frm[0..3] with the given spacing; returns the period of the last byte
    task automatic send_frame(input int spacing, output int t);
        for (int i = 0; i < 4; i++) begin
            cyc_drive(1'b0, 1'b1, frm[i], t);
            if (i < 3) idle(spacing - 1);
        end
    endtask

    task automatic push_valid(input int c, input logic [7:0] d, input logic [5:0] idx);
        expq.push_back('{1'b0, c, d, idx, 1'b0, 2'd0});
    endtask

    task automatic push_done(input int c, input logic err, input logic [1:0] code);
        expq.push_back('{1'b1, c, 8'h00, 6'd0, err, code});
    endtask

    // Good frame: payload at T+2..T+4, done at T+5
    task automatic push_good(input int t);
        for (int i = 0; i < 3; i++) push_valid(t + 2 + i, frm[i], 6'(i));
        push_done(t + 5, 1'b0, 2'd0);
    endtask

    task automatic set_frame(input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3);
        frm[0] = b0; frm[1] = b1; frm[2] = b2; frm[3] = b3;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " oData"},    32'(oData),    32'd0);
        chk({tag, " oIdx"},     32'(oIdx),     32'd0);
        chk({tag, " oValid"},   32'(oValid),   32'd0);
        chk({tag, " oDone"},    32'(oDone),    32'd0);
        chk({tag, " oErr"},     32'(oErr),     32'd0);
        chk({tag, " oErrCode"}, 32'(oErrCode), 32'd0);
        chk({tag, " oBusy"},    32'(oBusy),    32'd0);
    endtask

    task automatic check_stats(input string tag, input int ok, input int bad);
`ifdef LCB_RX_STATS_EN
        chk({tag, " oCntOk"},  32'(oCntOk),  ok);
        chk({tag, " oCntErr"}, 32'(oCntErr), bad);
`else
        chk({tag, " oCntOk"},  32'(oCntOk),  32'(ok * 0));
        chk({tag, " oCntErr"}, 32'(oCntErr), 32'(bad * 0));
`endif
    endtask

    initial begin
        int p;
        int t;
        reset  = 1'b1;
        iStart = 1'b0;
        iValid = 1'b0;
        iData  = 8'h00;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        check_stats("reset", 0, 0);
        reset = 1'b0;
        idle(3);

        // Good frame, bytes 10 cycles apart
        set_frame(8'hA5, 8'h01, 8'h02, 8'hA8);
        start(p);
        idle(4);
        chk("busy in window", 32'(oBusy), 32'd1);
        send_frame(10, t);
        push_good(t);
        idle(10);
        chk("idle after good", 32'(oBusy), 32'd0);

        // Bad checksum
        set_frame(8'hA5, 8'h01, 8'h02, 8'hA9);
        start(p);
        idle(4);
        send_frame(10, t);
        push_done(t + 2, 1'b1, 2'd2);
        idle(10);
        chk("code held after csum", 32'(oErrCode), 32'd2);

        // Wrong sync byte
        start(p);
        idle(3);
        cyc_drive(1'b0, 1'b1, 8'h5A, p);
        push_done(p + 1, 1'b1, 2'd3);
        idle(5);

        // Inter-byte gap timeout
        start(p);
        idle(4);
        cyc_drive(1'b0, 1'b1, 8'hA5, p);
        idle(9);
        cyc_drive(1'b0, 1'b1, 8'h01, p);
        push_done(p + 21, 1'b1, 2'd1);
        idle(30);

        // First-byte timeout
        start(p);
        push_done(p + 101, 1'b1, 2'd1);
        idle(110);

        // Largest accepted gap (19 cycles) still yields a good frame
        set_frame(8'hA5, 8'h01, 8'h02, 8'hA8);
        start(p);
        idle(4);
        send_frame(19, t);
        push_good(t);
        idle(10);

        // Reset, then abort by a second request and a good follow-up frame
        cyc_drive(1'b0, 1'b0, 8'h00, p);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_stats("after reset", 0, 0);
        start(p);
        idle(3);
        cyc_drive(1'b0, 1'b1, 8'hA5, p);
        idle(4);
        cyc_drive(1'b1, 1'b0, 8'h00, p);
        push_done(p + 1, 1'b1, 2'd3);
        idle(3);
        send_frame(10, t);
        push_good(t);
        idle(10);
        check_stats("after abort", 1, 1);

        // Reset during replay after the first payload byte
        start(p);
        idle(4);
        send_frame(10, t);
        push_valid(t + 2, frm[0], 6'd0);
        push_valid(t + 3, frm[1], 6'd1);
        idle(2);
        cyc_drive(1'b0, 1'b0, 8'h00, p);
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("reset in replay");
        reset = 1'b0;
        idle(5);

        // Normal frame after the mid-replay reset
        start(p);
        idle(4);
        send_frame(10, t);
        push_good(t);
        idle(10);
        check_stats("final", 1, 0);

        chk("pending expectations", 32'(expq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
